// File: rtl/maple_pattern_decoder.sv
// maple_pattern_decoder
//   Decodes Maple bus start-of-frame (SDCKA low, SDCKB pulsing) and end-of-frame
//   (SDCKB low, SDCKA pulsing) patterns from one-cycle line edge strobes.
//   Adds a gating enable, classified error codes and the captured pulse count.
//
// Optional feature: define MAPLE_PATTERN_TIMEOUT_EN to abort a pattern that
//   stays in a counting state for TIMEOUT_CYCLES clocks (error_code 3).
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset          asynchronous active-low reset
//   enable         decoder armed; low returns to IDLE at next clk
//   sdcka_posedge  strobe, SDCKA rising
//   sdcka_negedge  strobe, SDCKA falling
//   sdckb_posedge  strobe, SDCKB rising
//   sdckb_negedge  strobe, SDCKB falling
//   start_frame    one-cycle pulse, valid start pattern
//   end_frame      one-cycle pulse, valid end pattern
//   pattern_error  one-cycle pulse, malformed pattern
//   error_code     cause of last error (1 short, 2 long, 3 timeout, 4 collision), held
//   pulse_count    pulses counted in last completed pattern, held
module maple_pattern_decoder #(
  parameter int unsigned START_PULSES   = 4,
  parameter int unsigned END_PULSES     = 2,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TO_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sdcka_posedge,
  input  logic             sdcka_negedge,
  input  logic             sdckb_posedge,
  input  logic             sdckb_negedge,
  output logic             start_frame,
  output logic             end_frame,
  output logic             pattern_error,
  output logic [2:0]       error_code,
  output logic [CNT_W-1:0] pulse_count
);

  localparam logic [CNT_W-1:0] StartTarget = CNT_W'(START_PULSES);
  localparam logic [CNT_W-1:0] EndTarget   = CNT_W'(END_PULSES);

  localparam logic [2:0] ErrShort     = 3'd1;
  localparam logic [2:0] ErrLong      = 3'd2;
  localparam logic [2:0] ErrTimeout   = 3'd3;
  localparam logic [2:0] ErrCollision = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = 3'b001,
    StCntStart = 3'b010,
    StCntEnd   = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] pc_q, pc_d;

  // Count including any pulse seen this cycle, saturating at all-ones.
  logic [CNT_W-1:0] cnt_sat_inc;
  logic [CNT_W-1:0] final_cnt;
  logic [CNT_W-1:0] target;
  logic             is_start;
  logic             done;
  logic             timeout_hit;

  assign cnt_sat_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef MAPLE_PATTERN_TIMEOUT_EN
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_q, to_d;

  always_comb begin
    to_d        = '0;
    timeout_hit = 1'b0;
    if (state_q != StIdle) begin
      to_d        = to_q + TO_W'(1);
      timeout_hit = (to_q == ToLast);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_q <= '0;
    end else if (!enable || state_d == StIdle) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TO_W, TIMEOUT_CYCLES};
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    pc_d      = pc_q;
    final_cnt = cnt_q;
    target    = StartTarget;
    is_start  = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sdcka_negedge && sdckb_negedge) begin
          err_d  = 1'b1;
          code_d = ErrCollision;
        end else if (sdcka_negedge) begin
          state_d = StCntStart;
        end else if (sdckb_negedge) begin
          state_d = StCntEnd;
        end
      end
      StCntStart: begin
        final_cnt = sdckb_negedge ? cnt_sat_inc : cnt_q;
        target    = StartTarget;
        is_start  = 1'b1;
        done      = sdcka_posedge;
        cnt_d     = final_cnt;
      end
      StCntEnd: begin
        final_cnt = sdcka_negedge ? cnt_sat_inc : cnt_q;
        target    = EndTarget;
        done      = sdckb_posedge;
        cnt_d     = final_cnt;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Completion takes priority over a coincident timeout.
    if (done) begin
      state_d = StIdle;
      cnt_d   = '0;
      pc_d    = final_cnt;
      if (final_cnt == target) begin
        start_d = is_start;
        end_d   = !is_start;
      end else if (final_cnt != '0) begin
        err_d  = 1'b1;
        code_d = (final_cnt < target) ? ErrShort : ErrLong;
      end
    end else if (timeout_hit) begin
      state_d = StIdle;
      cnt_d   = '0;
      pc_d    = final_cnt;
      err_d   = 1'b1;
      code_d  = ErrTimeout;
    end

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      start_d = 1'b0;
      end_d   = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      pc_d    = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      end_q   <= end_d;
      err_q   <= err_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
    end
  end

  assign start_frame   = start_q;
  assign end_frame     = end_q;
  assign pattern_error = err_q;
  assign error_code    = code_q;
  assign pulse_count   = pc_q;

endmodule

// File: tb/tb_maple_pattern_decoder.sv
// Bench for maple_pattern_decoder: patterns are generated as transactions
// (kind, pulse count, merge, noise); the expected result of each transaction is
// derived from its pulse count and queued; a monitor pops on every output pulse.
module tb_maple_pattern_decoder;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TO_CYC = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             sdcka_posedge = 1'b0;
  logic             sdcka_negedge = 1'b0;
  logic             sdckb_posedge = 1'b0;
  logic             sdckb_negedge = 1'b0;
  logic             start_frame;
  logic             end_frame;
  logic             pattern_error;
  logic [2:0]       error_code;
  logic [CNT_W-1:0] pulse_count;

  maple_pattern_decoder #(
    .START_PULSES  (4),
    .END_PULSES    (2),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TO_CYC),
    .TO_W          (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sdcka_posedge(sdcka_posedge),
    .sdcka_negedge(sdcka_negedge),
    .sdckb_posedge(sdckb_posedge),
    .sdckb_negedge(sdckb_negedge),
    .start_frame  (start_frame),
    .end_frame    (end_frame),
    .pattern_error(pattern_error),
    .error_code   (error_code),
    .pulse_count  (pulse_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int pulses_seen = 0;
  int drive_cyc = 0;

  typedef struct {
    int         cyc;
    logic       s;
    logic       e;
    logic       er;
    logic [2:0] code;
    logic [7:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int   mon_n;

  // Reference state: values the held outputs should carry.
  logic [2:0] m_code = 3'd0;
  logic [7:0] m_pc = 8'd0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic s, input logic e, input logic er);
    exp_t x;
    x.cyc  = c;
    x.s    = s;
    x.e    = e;
    x.er   = er;
    x.code = m_code;
    x.pc   = m_pc;
    q.push_back(x);
  endtask

  // Monitor: pops an expectation whenever the DUT pulses; flags stale entries.
  always @(negedge clk) begin
    if (reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_pulse", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      mon_n = int'(start_frame) + int'(end_frame) + int'(pattern_error);
      if (mon_n > 1) chk("exclusive_outputs", mon_n, 1);
      if (mon_n != 0) begin
        pulses_seen++;
        if (q.size() == 0) begin
          chk("unexpected_pulse", mon_n, 0);
        end else begin
          mon_x = q.pop_front();
          chk("latency", cyc, mon_x.cyc);
          chk("start_frame", int'(start_frame), int'(mon_x.s));
          chk("end_frame", int'(end_frame), int'(mon_x.e));
          chk("pattern_error", int'(pattern_error), int'(mon_x.er));
          chk("error_code", int'(error_code), int'(mon_x.code));
          chk("pulse_count", int'(pulse_count), int'(mon_x.pc));
        end
      end
    end
  end

  // One clock of stimulus, applied at the falling edge.
  task automatic step(input logic ap, input logic an, input logic bp, input logic bn);
    @(negedge clk);
    enable        = 1'b1;
    sdcka_posedge = ap;
    sdcka_negedge = an;
    sdckb_posedge = bp;
    sdckb_negedge = bn;
    drive_cyc     = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic rbit(input bit en);
    return en ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Strobes ignored while counting: start ignores a_neg/b_pos, end ignores b_neg/a_pos.
  task automatic count_cycle(input bit is_start, input bit pulse, input bit fin, input bit noise);
    if (is_start) step(fin, rbit(noise), rbit(noise), pulse);
    else          step(rbit(noise), pulse, fin, rbit(noise));
  endtask

  task automatic send_pattern(input bit is_start, input int n, input bit merge_in, input bit noise);
    int  target;
    int  f;
    bit  merge;
    merge  = merge_in && (n > 0);
    target = is_start ? 4 : 2;
    if (is_start) step(1'b0, 1'b1, 1'b0, 1'b0);
    else          step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) count_cycle(is_start, 1'b0, 1'b0, noise);
      if (!(merge && i == n - 1)) count_cycle(is_start, 1'b1, 1'b0, noise);
    end
    repeat ($urandom_range(0, 1)) count_cycle(is_start, 1'b0, 1'b0, noise);
    count_cycle(is_start, merge, 1'b1, noise);
    f    = (n > 255) ? 255 : n;
    m_pc = 8'(f);
    if (f == target) begin
      push_exp(drive_cyc + 1, is_start, !is_start, 1'b0);
    end else if (f != 0) begin
      m_code = (f < target) ? 3'd1 : 3'd2;
      push_exp(drive_cyc + 1, 1'b0, 1'b0, 1'b1);
    end else begin
      idle(1);
      chk("glitch_pulse_count", int'(pulse_count), 0);
    end
  endtask

  task automatic collision();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    m_code = 3'd4;
    push_exp(drive_cyc + 1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic enable_drop(input bit is_start, input int k);
    if (is_start) step(1'b0, 1'b1, 1'b0, 1'b0);
    else          step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < k; i++) count_cycle(is_start, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    enable        = 1'b0;
    sdcka_posedge = rbit(1'b1);
    sdcka_negedge = rbit(1'b1);
    sdckb_posedge = rbit(1'b1);
    sdckb_negedge = rbit(1'b1);
  endtask

  task automatic gap(input int n);
    repeat (n) step(rbit(1'b1), 1'b0, rbit(1'b1), 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen0;
    repeat (3) @(negedge clk);
    chk("reset_start_frame", int'(start_frame), 0);
    chk("reset_end_frame", int'(end_frame), 0);
    chk("reset_pattern_error", int'(pattern_error), 0);
    chk("reset_error_code", int'(error_code), 0);
    chk("reset_pulse_count", int'(pulse_count), 0);
    reset = 1'b1;
    idle(2);

    // Directed: start 4, end 2/3/1/0 back-to-back.
    send_pattern(1'b1, 4, 1'b0, 1'b0);
    send_pattern(1'b0, 2, 1'b0, 1'b0);
    send_pattern(1'b0, 3, 1'b0, 1'b0);
    send_pattern(1'b0, 1, 1'b0, 1'b0);
    send_pattern(1'b0, 0, 1'b0, 1'b0);
    collision();
    send_pattern(1'b0, 2, 1'b1, 1'b0);
    idle(2);

    // Reset mid-pattern after 2 of 4 start pulses.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    sdckb_negedge = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midreset_start_frame", int'(start_frame), 0);
    chk("midreset_pattern_error", int'(pattern_error), 0);
    chk("midreset_error_code", int'(error_code), 0);
    chk("midreset_pulse_count", int'(pulse_count), 0);
    @(negedge clk);
    reset  = 1'b1;
    m_pc   = 8'd0;
    m_code = 3'd0;
    send_pattern(1'b1, 4, 1'b0, 1'b0);

    // Enable drop mid end pattern, then back-to-back end and start.
    enable_drop(1'b0, 1);
    send_pattern(1'b0, 2, 1'b0, 1'b0);
    send_pattern(1'b1, 4, 1'b0, 1'b0);
    idle(2);

    // Silence inside a counting state.
    seen0 = pulses_seen;
    step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef MAPLE_PATTERN_TIMEOUT_EN
    m_pc   = 8'd0;
    m_code = 3'd3;
    push_exp(drive_cyc + 1 + int'(TO_CYC), 1'b0, 1'b0, 1'b1);
    idle(100);
    chk("timeout_pulses", pulses_seen - seen0, 1);
`else
    idle(100);
    chk("silence_no_pulse", pulses_seen - seen0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    m_pc = 8'd0;
    idle(1);
    chk("silence_glitch_pc", int'(pulse_count), 0);
`endif

    // Randomized transactions.
    for (int t = 0; t < 80; t++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      collision();
      else if (kind == 1) enable_drop(bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      else send_pattern(bit'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                        bit'($urandom_range(0, 1)), 1'b1);
      gap(int'($urandom_range(0, 2)));
    end

    idle(4);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
